// File: rtl/mem_responder.sv
// Byte-addressed word RAM responder with wait states and byte/half/word sizes.
// Ports: Clk, reset (sync, low); req/wr/Size/Address/Datain in; Dataout/ready/err/busy out.
module mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 1
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  Size,
  input  logic [31:0] Address,
  input  logic [31:0] Datain,
  output logic [31:0] Dataout,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
  localparam logic [2:0] LAT = 3'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]            r_cnt;
  logic                  r_wr;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_data;
  logic [31:0]           r_mem [WORDS];
  logic                  r_ready;
  logic                  r_err;
  logic                  r_busy;
  logic [31:0]           r_dout;

  logic                    w_acc;
  logic                    w_in_err;
  logic                    w_wait;
  logic                    w_enter;
  logic                    w_err_resp;
  logic                    w_commit;
  logic                    w_wr;
  logic [1:0]              w_size;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [31:0]             w_data;
  logic [ADDR_WIDTH-3:0]   w_idx;
  logic [1:0]              w_lane;
  logic [3:0]              w_be;
  logic [31:0]             w_wd;
  logic [31:0]             w_old;
  logic [31:0]             w_new;
  logic [31:0]             w_rd;

  assign w_wait = (r_state == S_WAIT);
  assign w_acc  = req && !w_wait;

  always_comb begin
    w_in_err = 1'b0;
    if (Size == 2'b11)
      w_in_err = 1'b1;
    if ((Address >> ADDR_WIDTH) != 32'd0)
      w_in_err = 1'b1;
    if (Size == 2'b10 && Address[0])
      w_in_err = 1'b1;
    if (Size == 2'b00 && Address[1:0] != 2'b00)
      w_in_err = 1'b1;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_RESP: begin
        if (req)
          w_next = (w_in_err || LAT == 3'd0) ? S_RESP : S_WAIT;
        else
          w_next = S_IDLE;
      end
      S_WAIT: begin
        if (r_cnt <= 3'd1)
          w_next = S_RESP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter    = (w_next == S_RESP);
  assign w_err_resp = w_acc && w_in_err;
  assign w_commit   = w_enter && !w_err_resp;

  // Zero-latency accesses commit on the accept edge, so use live inputs.
  assign w_wr   = w_wait ? r_wr   : wr;
  assign w_size = w_wait ? r_size : Size;
  assign w_addr = w_wait ? r_addr : Address[ADDR_WIDTH-1:0];
  assign w_data = w_wait ? r_data : Datain;

  assign w_idx  = w_addr[ADDR_WIDTH-1:2];
  assign w_lane = w_addr[1:0];
  assign w_old  = r_mem[w_idx];

  always_comb begin
    w_be = 4'hF;
    w_wd = w_data;
    unique case (w_size)
      2'b01: begin
        w_be = 4'b0001 << w_lane;
        w_wd = {4{w_data[7:0]}};
      end
      2'b10: begin
        w_be = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{w_data[15:0]}};
      end
      default: begin
        w_be = 4'hF;
        w_wd = w_data;
      end
    endcase
  end

  // Read sees the word after any same-edge write merge.
  always_comb begin
    for (int k = 0; k < 4; k++)
      w_new[8*k +: 8] = (w_wr && w_be[k]) ? w_wd[8*k +: 8]
                                          : w_old[8*k +: 8];
  end

  always_comb begin
    w_rd = w_new;
    unique case (w_size)
      2'b01:   w_rd = {24'd0, w_new[{w_lane, 3'b000} +: 8]};
      2'b10:   w_rd = {16'd0, w_new[{w_lane[1], 4'b0000} +: 16]};
      default: w_rd = w_new;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_dout  <= 32'd0;
    end else begin
      r_state <= w_next;
      r_ready <= w_enter;
      r_busy  <= (w_next == S_WAIT);
      r_err   <= w_err_resp;
      if (w_enter)
        r_dout <= w_err_resp ? 32'd0 : w_rd;
      if (w_acc)
        r_cnt <= w_in_err ? 3'd0 : LAT;
      else if (w_wait && r_cnt != 3'd0)
        r_cnt <= r_cnt - 3'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_acc) begin
      r_wr   <= wr;
      r_size <= Size;
      r_addr <= Address[ADDR_WIDTH-1:0];
      r_data <= Datain;
    end
  end

  // Memory survives reset; a commit coinciding with reset is dropped.
  always_ff @(posedge Clk) begin
    if (reset && w_commit && w_wr)
      r_mem[w_idx] <= w_new;
  end

  assign Dataout = r_dout;
  assign ready   = r_ready;
  assign err     = r_err;
  assign busy    = r_busy;

endmodule
